// File: rtl/score_keeper.sv
// score_keeper: game state machine, BCD score, countdown timer and
// seven-segment encoding for the pinball screen renderer.
// Optional feature macro: SCORE_KEEPER_BONUS_EN (each hundreds crossing
// of the score while running adds 5 seconds, saturating at 99).
module score_keeper #(
  parameter int TICK_DIV     = 50000000,
  parameter int GAME_SECONDS = 60,
  parameter int BIG_POINTS   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startbutton,
  input  logic [3:0]  hit,
  output logic [11:0] score_bcd,
  output logic [7:0]  time_bcd,
  output logic [20:0] score_seg,
  output logic [13:0] time_seg,
  output logic [1:0]  state,
  output logic        game_over
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int                TICK_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [7:0]        TIME_INIT = {4'(GAME_SECONDS / 10), 4'(GAME_SECONDS % 10)};
  localparam logic [3:0]        BIG       = 4'(BIG_POINTS);

  // Standard a..g pattern, bit0 = a; codes above 9 render blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  state_t              r_state;
  state_t              w_state_next;
  logic [TICK_W-1:0]   r_tick;
  logic [3:0]          r_hit_q;
  logic [11:0]         r_score;
  logic [7:0]          r_time;
  logic [20:0]         r_score_seg;
  logic [13:0]         r_time_seg;
  logic                r_game_over;

  // Hit edges and points awarded this cycle (0 .. 2 + 2*BIG_POINTS).
  logic [3:0] w_rise;
  logic [4:0] w_points;
  logic [3:0] w_add_tens;
  logic [3:0] w_add_ones;

  assign w_rise   = hit & ~r_hit_q;
  assign w_points = {4'd0, w_rise[0]} + {4'd0, w_rise[1]}
                  + (w_rise[2] ? {1'b0, BIG} : 5'd0)
                  + (w_rise[3] ? {1'b0, BIG} : 5'd0);

  // Split the binary point count into a two-digit BCD addend.
  // NOTE: every output of a combinational block gets a default first so no latch can be inferred.
  always_comb begin
    w_add_tens = 4'd0;
    w_add_ones = w_points[3:0];
    if (w_points >= 5'd20) begin
      w_add_tens = 4'd2;
      w_add_ones = 4'(w_points - 5'd20);
    end else if (w_points >= 5'd10) begin
      w_add_tens = 4'd1;
      w_add_ones = 4'(w_points - 5'd10);
    end
  end

  // Three-digit BCD adder with per-digit carry, saturating at 999.
  logic [4:0]  w_d0_raw, w_d1_raw, w_d2_raw;
  logic        w_c0, w_c1;
  logic [3:0]  w_d0, w_d1;
  logic [11:0] w_score_sum;

  assign w_d0_raw    = {1'b0, r_score[3:0]} + {1'b0, w_add_ones};
  assign w_c0        = (w_d0_raw > 5'd9);
  assign w_d0        = w_c0 ? 4'(w_d0_raw - 5'd10) : w_d0_raw[3:0];
  assign w_d1_raw    = {1'b0, r_score[7:4]} + {1'b0, w_add_tens} + {4'd0, w_c0};
  assign w_c1        = (w_d1_raw > 5'd9);
  assign w_d1        = w_c1 ? 4'(w_d1_raw - 5'd10) : w_d1_raw[3:0];
  assign w_d2_raw    = {1'b0, r_score[11:8]} + {4'd0, w_c1};
  assign w_score_sum = (w_d2_raw > 5'd9) ? 12'h999 : {w_d2_raw[3:0], w_d1, w_d0};

  // Countdown: BCD decrement on each tick wrap while running.
  logic       w_wrap;
  logic [7:0] w_time_dec;
  logic [7:0] w_time_run;
  logic [7:0] w_time_next;

  assign w_wrap     = (r_state == S_RUN) && (r_tick == TICK_LAST);
  assign w_time_dec = (r_time[3:0] == 4'd0) ? {r_time[7:4] - 4'd1, 4'd9}
                                            : {r_time[7:4], r_time[3:0] - 4'd1};
  assign w_time_run = w_wrap ? w_time_dec : r_time;

`ifdef SCORE_KEEPER_BONUS_EN
  // A hundreds crossing adds 5 s after any decrement, so a crossing on the
  // edge that would load 00 keeps the game running.
  logic       w_bonus;
  logic [4:0] w_p5_ones;
  logic [3:0] w_p5_tens;
  logic [7:0] w_time_p5;

  assign w_bonus   = (w_score_sum[11:8] != r_score[11:8]);
  assign w_p5_ones = {1'b0, w_time_run[3:0]} + 5'd5;
  assign w_p5_tens = (w_p5_ones > 5'd9) ? w_time_run[7:4] + 4'd1 : w_time_run[7:4];
  assign w_time_p5 = (w_p5_tens > 4'd9) ? 8'h99
                   : {w_p5_tens, (w_p5_ones > 5'd9) ? 4'(w_p5_ones - 5'd10) : w_p5_ones[3:0]};
  assign w_time_next = w_bonus ? w_time_p5 : w_time_run;
`else
  assign w_time_next = w_time_run;
`endif

  // Next-state logic for the game FSM.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (startbutton) w_state_next = S_RUN;
      S_RUN: begin
        if (w_time_next == 8'h00) w_state_next = S_OVER;
        else if (!startbutton)    w_state_next = S_PAUSE;
      end
      S_PAUSE: if (startbutton)  w_state_next = S_RUN;
      S_OVER:  if (!startbutton) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register and registered game_over flag.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_game_over <= (w_state_next == S_OVER);
    end
  end

  // Datapath: hit history, tick counter, score, time and segment masks.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tick      <= '0;
      r_hit_q     <= 4'd0;
      r_score     <= 12'h000;
      r_time      <= TIME_INIT;
      r_score_seg <= {seg7(4'd0), seg7(4'd0), seg7(4'd0)};
      r_time_seg  <= {seg7(TIME_INIT[7:4]), seg7(TIME_INIT[3:0])};
    end else begin
      r_hit_q     <= hit;
      r_score_seg <= {seg7(r_score[11:8]), seg7(r_score[7:4]), seg7(r_score[3:0])};
      r_time_seg  <= {seg7(r_time[7:4]), seg7(r_time[3:0])};
      case (r_state)
        S_IDLE: r_tick <= '0;
        S_RUN: begin
          r_tick  <= w_wrap ? '0 : r_tick + 1'b1;
          r_score <= w_score_sum;
          r_time  <= w_time_next;
        end
        S_OVER: begin
          if (!startbutton) begin
            r_score <= 12'h000;
            r_time  <= TIME_INIT;
          end
        end
        default: ;
      endcase
    end
  end

  assign score_bcd = r_score;
  assign time_bcd  = r_time;
  assign score_seg = r_score_seg;
  assign time_seg  = r_time_seg;
  assign state     = r_state;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: a short-game instance (A) for the
// countdown/pause/hit-scoring behaviour and a long-game instance (B) for
// high scores, saturation and the optional time bonus, both compared every
// cycle against an integer-level reference model, plus random stimulus.
module tb_score_keeper;

  localparam int TD_A = 10;
  localparam int GS_A = 3;
  localparam int TD_B = 8;
  localparam int GS_B = 99;
  localparam int BP   = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sb_a, sb_b;
  logic [3:0]  hit_a, hit_b;
  logic [11:0] score_bcd_a, score_bcd_b;
  logic [7:0]  time_bcd_a, time_bcd_b;
  logic [20:0] score_seg_a, score_seg_b;
  logic [13:0] time_seg_a, time_seg_b;
  logic [1:0]  state_a, state_b;
  logic        game_over_a, game_over_b;

  score_keeper #(.TICK_DIV(TD_A), .GAME_SECONDS(GS_A), .BIG_POINTS(BP)) u_dut_a (
    .clk(clk), .rst(rst), .startbutton(sb_a), .hit(hit_a),
    .score_bcd(score_bcd_a), .time_bcd(time_bcd_a), .score_seg(score_seg_a),
    .time_seg(time_seg_a), .state(state_a), .game_over(game_over_a)
  );

  score_keeper #(.TICK_DIV(TD_B), .GAME_SECONDS(GS_B), .BIG_POINTS(BP)) u_dut_b (
    .clk(clk), .rst(rst), .startbutton(sb_b), .hit(hit_b),
    .score_bcd(score_bcd_b), .time_bcd(time_bcd_b), .score_seg(score_seg_b),
    .time_seg(time_seg_b), .state(state_b), .game_over(game_over_b)
  );

  // Reference model state: plain integers; seg_* hold the value shown by
  // the (one cycle later) segment outputs. state: 0 idle,1 run,2 pause,3 over.
  typedef struct packed {
    int         state;
    int         score;
    int         tim;
    int         tick;
    logic [3:0] hist;
    int         seg_score;
    int         seg_time;
  } model_t;

  model_t ma, mb;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic model_t model_step(input model_t m, input logic r, input logic s,
                                        input logic [3:0] h, input int td, input int gs);
    model_t     n;
    logic [3:0] rise;
    int         pts;
    int         t;
    n = m;
    if (r) begin
      n.state = 0; n.score = 0; n.tim = gs; n.tick = 0; n.hist = 4'd0;
      n.seg_score = 0; n.seg_time = gs;
      return n;
    end
    n.seg_score = m.score;
    n.seg_time  = m.tim;
    rise   = h & ~m.hist;
    n.hist = h;
    case (m.state)
      0: if (s) begin n.state = 1; n.tick = 0; end
      1: begin
        pts = int'(rise[0]) + int'(rise[1]) + (rise[2] ? BP : 0) + (rise[3] ? BP : 0);
        n.score = (m.score + pts > 999) ? 999 : m.score + pts;
        t = m.tim;
        if (m.tick == td - 1) begin t = t - 1; n.tick = 0; end
        else n.tick = m.tick + 1;
`ifdef SCORE_KEEPER_BONUS_EN
        if (n.score / 100 > m.score / 100) t = (t + 5 > 99) ? 99 : t + 5;
`endif
        n.tim = t;
        if (t == 0)  n.state = 3;
        else if (!s) n.state = 2;
      end
      2: if (s) n.state = 1;
      default: if (!s) begin n.state = 0; n.score = 0; n.tim = gs; end
    endcase
    return n;
  endfunction

  function automatic logic [3:0] dig(input int v);
    return 4'(v);
  endfunction

  function automatic logic [11:0] bcd3(input int v);
    return {dig(v / 100), dig((v / 10) % 10), dig(v % 10)};
  endfunction

  function automatic logic [7:0] bcd2(input int v);
    return {dig(v / 10), dig(v % 10)};
  endfunction

  function automatic logic [6:0] seg_digit(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [20:0] seg3(input int v);
    return {seg_digit(v / 100), seg_digit((v / 10) % 10), seg_digit(v % 10)};
  endfunction

  function automatic logic [13:0] seg2(input int v);
    return {seg_digit(v / 10), seg_digit(v % 10)};
  endfunction

  task automatic compare_all();
    check("a_state",     32'(state_a),     32'(ma.state));
    check("a_score",     32'(score_bcd_a), 32'(bcd3(ma.score)));
    check("a_time",      32'(time_bcd_a),  32'(bcd2(ma.tim)));
    check("a_score_seg", 32'(score_seg_a), 32'(seg3(ma.seg_score)));
    check("a_time_seg",  32'(time_seg_a),  32'(seg2(ma.seg_time)));
    check("a_game_over", 32'(game_over_a), 32'(ma.state == 3));
    check("b_state",     32'(state_b),     32'(mb.state));
    check("b_score",     32'(score_bcd_b), 32'(bcd3(mb.score)));
    check("b_time",      32'(time_bcd_b),  32'(bcd2(mb.tim)));
    check("b_score_seg", 32'(score_seg_b), 32'(seg3(mb.seg_score)));
    check("b_time_seg",  32'(time_seg_b),  32'(seg2(mb.seg_time)));
    check("b_game_over", 32'(game_over_b), 32'(mb.state == 3));
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic sa, input logic [3:0] ha,
                      input logic sbb, input logic [3:0] hb);
    @(negedge clk);
    rst = r; sb_a = sa; hit_a = ha; sb_b = sbb; hit_b = hb;
    @(posedge clk);
    #1;
    ma = model_step(ma, r, sa, ha, TD_A, GS_A);
    mb = model_step(mb, r, sbb, hb, TD_B, GS_B);
    compare_all();
  endtask

  // Pulse hit patterns on B (running) until the model score reaches target.
  task automatic add_b(input int target);
    int         guard;
    int         rem;
    logic [3:0] p;
    guard = 0;
    while (mb.score < target && guard < 200) begin
      rem = target - mb.score;
      if      (rem >= 12) p = 4'b1111;
      else if (rem >= 11) p = 4'b1101;
      else if (rem >= 10) p = 4'b1100;
      else if (rem >= 7)  p = 4'b0111;
      else if (rem >= 6)  p = 4'b0101;
      else if (rem >= 5)  p = 4'b0100;
      else if (rem >= 2)  p = 4'b0011;
      else                p = 4'b0001;
      step(1'b0, 1'b0, 4'd0, 1'b1, p);
      step(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
      guard++;
    end
    check("b_add_reach", 32'(score_bcd_b), 32'(bcd3(target)));
  endtask

  task automatic finish_a();
    int n;
    n = 0;
    while (ma.state != 3 && n < 200) begin
      step(1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
      n++;
    end
    check("a_game_end", 32'(state_a), 32'd3);
    step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    check("a_back_idle", 32'(state_a), 32'd0);
  endtask

  task automatic finish_b();
    int n;
    n = 0;
    while (mb.state != 3 && n < 1000) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
      n++;
    end
    check("b_game_end", 32'(state_b), 32'd3);
    step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    check("b_back_idle", 32'(state_b), 32'd0);
  endtask

  initial begin
    int         n;
    logic [7:0] prev;
    logic       ra, rb_sb;
    logic [3:0] rha, rhb;
    rst = 1'b1; sb_a = 1'b0; sb_b = 1'b0; hit_a = 4'd0; hit_b = 4'd0;

    // Reset hold.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0);
    check("reset_state",     32'(state_a),          32'd0);
    check("reset_score",     32'(score_bcd_a),      32'h000);
    check("reset_time",      32'(time_bcd_a),       32'h03);
    check("reset_time_seg0", 32'(time_seg_a[6:0]),  32'b1001111);
    check("reset_game_over", 32'(game_over_a),      32'd0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);

    // Countdown with startbutton held and no hits.
    step(1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      prev = time_bcd_a;
      n = 0;
      do begin
        step(1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
        n++;
      end while (time_bcd_a == prev && n < 40);
      check("countdown_period", 32'(n), 32'd10);
    end
    check("countdown_zero",  32'(time_bcd_a),  32'h00);
    check("countdown_over",  32'(state_a),     32'd3);
    check("countdown_flag",  32'(game_over_a), 32'd1);
    step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    check("over_to_idle",    32'(state_a),     32'd0);
    check("over_reload",     32'(time_bcd_a),  32'h03);

    // Hit scoring: a held hit scores once; all four bumpers sum with carry.
    step(1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'b0001, 1'b0, 4'd0);
    check("held_hit_once", 32'(score_bcd_a), 32'h001);
    step(1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'b1111, 1'b0, 4'd0);
    check("all_bumpers", 32'(score_bcd_a), 32'h013);
    step(1'b0, 1'b1, 4'd0, 1'b0, 4'd0);

    // Hits during PAUSE are consumed.
    step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    check("pause_entry", 32'(state_a), 32'd2);
    step(1'b0, 1'b0, 4'b1111, 1'b0, 4'd0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
    check("pause_no_score", 32'(score_bcd_a), 32'h013);
    finish_a();

    // Hits in IDLE and a hit held across RUN entry never score.
    step(1'b0, 1'b0, 4'b1111, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'b1111, 1'b0, 4'd0);
    check("idle_consumed", 32'(score_bcd_a), 32'h000);
    step(1'b0, 1'b1, 4'd0, 1'b0, 4'd0);

    // Pause at tick count 7, hold, resume: decrement 3 cycles after resume.
    n = 0;
    while (ma.tick != 7 && n < 20) begin
      step(1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
      n++;
    end
    check("reach_tick7", 32'(n < 20), 32'd1);
    step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    check("pause_state", 32'(state_a), 32'd2);
    prev = time_bcd_a;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    check("pause_time_hold", 32'(time_bcd_a), 32'(prev));
    n = 0;
    do begin
      step(1'b0, 1'b1, 4'd0, 1'b0, 4'd0);
      n++;
    end while (time_bcd_a == prev && n < 20);
    check("resume_latency", 32'(n), 32'd3);
    finish_a();

    // B game 1: score 098 at time 02, then a big hit crosses 100.
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    add_b(98);
    n = 0;
    while (mb.tim != 2 && n < 1000) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
      n++;
    end
    check("b_reach_t2", 32'(time_bcd_b), 32'h02);
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'b0100);
    check("cross_score", 32'(score_bcd_b), 32'h103);
`ifdef SCORE_KEEPER_BONUS_EN
    check("cross_time", 32'(time_bcd_b), 32'h07);
`else
    check("cross_time", 32'(time_bcd_b), 32'h02);
`endif
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    finish_b();

    // B game 2: saturation at 999.
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    add_b(995);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 4'b0100);
      check("saturate", 32'(score_bcd_b), 32'h999);
      step(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    end
    finish_b();

    // B game 3: crossing hit on the same edge that loads 00.
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    add_b(198);
    n = 0;
    while (!(mb.tim == 1 && mb.tick == TD_B - 1) && n < 1000) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
      n++;
    end
    check("b_reach_last", 32'(time_bcd_b), 32'h01);
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'b0100);
    check("last_edge_score", 32'(score_bcd_b), 32'h203);
`ifdef SCORE_KEEPER_BONUS_EN
    check("last_edge_time",  32'(time_bcd_b), 32'h05);
    check("last_edge_state", 32'(state_b),    32'd1);
`else
    check("last_edge_time",  32'(time_bcd_b), 32'h00);
    check("last_edge_state", 32'(state_b),    32'd3);
`endif
    step(1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
    finish_b();

    // Random phase: occasional resets, button toggles, sparse hit toggles.
    ra = 1'b0; rb_sb = 1'b0; rha = 4'd0; rhb = 4'd0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) ra = ~ra;
      if ($urandom_range(0, 59) == 0) rb_sb = ~rb_sb;
      rha = rha ^ 4'($urandom & $urandom);
      rhb = rhb ^ 4'($urandom & $urandom);
      step(($urandom_range(0, 399) == 0), ra, rha, rb_sb, rhb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
# score_keeper

Game-state, score and countdown-timer block for the pinball design. Consumes per-bumper collision flags and the start switch. Produces BCD score/time values and seven-segment masks, which the VGA screen renderer paints into its right-hand score and time boxes. Sits directly upstream of the screen module, in the same `clk` domain.

## Interface
- `TICK_DIV`, 50000000, `clk` cycles per game second (≥2).
- `GAME_SECONDS`, 60, initial countdown value (1..99).
- `BIG_POINTS`, 5, points for bumpers 2 and 3 (1..9); bumpers 0 and 1 score 1.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `startbutton`  in  1  game-enable switch, level.
- `hit`  in  4  bumper collision flags, one per round bumper, level (held while overlapping).
- `score_bcd`  out  12  three BCD digits, [11:8] = hundreds.
- `time_bcd`  out  8  two BCD digits, [7:4] = tens.
- `score_seg`  out  21  seven-segment masks, 7 bits per digit, hundreds in [20:14]; in each digit bit0 = a … bit6 = g, active high.
- `time_seg`  out  14  seven-segment masks, tens in [13:7].
- `state`  out  2  0 = IDLE, 1 = RUN, 2 = PAUSE, 3 = OVER.
- `game_over`  out  1  high in OVER.

## Operation
- Reset values: `state` = IDLE, `score_bcd` = 000, `time_bcd` = `GAME_SECONDS`, tick counter = 0, `hit` history = 0. `score_seg` and `time_seg` show "000" and `GAME_SECONDS` from the first cycle after reset.
- State transitions:
  - IDLE → RUN when `startbutton` = 1; the tick counter clears on entry.
  - RUN → PAUSE when `startbutton` = 0.
  - PAUSE → RUN when `startbutton` = 1; the tick counter and time are preserved.
  - RUN → OVER when time reaches 00.
  - OVER → IDLE when `startbutton` = 0; score and time reload to the reset values on this transition.
- Tick counter: counts 0..`TICK_DIV`-1 only in RUN. On wrap, time decrements by 1 in BCD (10 → 09). If the decrement produces 00, the state moves to OVER on the same edge.
- Hit detection:
  - A hit is a rising edge of `hit[i]`, compared against a 1-cycle history register that updates every cycle in all states.
  - Hits score only in RUN. Edges seen in other states are consumed and never scored later.
  - Simultaneous rising edges on several bits sum in one cycle; the maximum add is 1+1+2·`BIG_POINTS`.
- Score arithmetic: a three-digit BCD adder with per-digit carry. The score saturates at 999 and never wraps.
- Segment encode for digits 0–9 is the standard pattern (e.g. 1 = b,c = 7'b0000110; 8 = 7'b1111111). Non-BCD codes map to 0.

## Timing
- `hit[i]` rises before edge N → `score_bcd` updated after edge N → `score_seg` updated after edge N+1.
- Tick wrap at edge N → `time_bcd` updated after edge N; `time_seg` after N+1.
- In the final second, `state` = OVER after the same edge that loads 00.
- Same-edge collisions:
  - A hit on the edge where time reaches 00 is still scored.
  - A hit on the edge where `startbutton` falls is scored, because the state is still RUN.
- `rst` overrides everything. Reset mid-game returns to IDLE on the next edge with the reset values.
- `state` and `game_over` are registered; no combinational path from inputs to outputs.

## Configuration
- `SCORE_KEEPER_BONUS_EN` defined:
  - Each time the score crosses a hundreds boundary (hundreds digit increments) in RUN, time gains 5 seconds, saturating at 99.
  - If the crossing edge is also the edge where time would reach 00, the bonus wins and the state stays RUN.
- Not defined: no bonus logic; time only decrements.

## Test plan
- Reset hold: `TICK_DIV`=10, `GAME_SECONDS`=3, hold `rst` 3 cycles → `state`=0, `score_bcd`=12'h000, `time_bcd`=8'h03, `time_seg`[6:0]=7'b1001111, `game_over`=0.
- Countdown: `startbutton`=1 held, no hits → `time_bcd` 03→02→01→00 at cycles 10/20/30 after entering RUN; `state`=3 on the cycle 00 loads. Then drop `startbutton` → IDLE, `time_bcd`=03.
- Hit scoring: in RUN, hold `hit[0]` high 50 cycles → score +1 only. Pulse `hit`=4'b1111 for 1 cycle with `BIG_POINTS`=5 → score +12 (e.g. 001→013), digit carry correct.
- Saturation: preload score to 995 via hits, then pulse `hit[2]` twice → 999 stays 999. Hits during PAUSE and IDLE → no change.
- Pause/resume: drop `startbutton` at tick count 7 → `state`=2 and the counter holds. Resume → next decrement 3 cycles later.
- Bonus (macro defined): score 098, `time_bcd`=02, pulse `hit[2]` → score 103, time 07. Score 198 with a tick wrap loading 00 on the same edge as a crossing hit → time 05, `state`=RUN.
